fb_rect_writer: RTL and testbench

Framebuffer write engine: the producer on the write port of the 2^20 x 12-bit synchronous pixel RAM that the pixel generator reads during scan-out. After reset it clears the whole visible area to a fixed colour. It then accepts rectangle-fill commands over a valid/ready handshake and emits one RAM write per cycle in raster order. Its address and data formats match the reader exactly: address {x[9:0], y[9:0]}, data RGB 4:4:4 as {r[3:0], g[3:0], b[3:0]}.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_scan_counter.sv | 55 +++++
 rtl/fb_rect_writer.sv | 160 ++++++++++++++++
 tb/tb_fb_rect_writer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the write engine and the scan-out reader.
package fb_pkg;

  localparam int FB_H_ACTIVE = 640;
  localparam int FB_V_ACTIVE = 480;
  localparam int FB_COORD_W  = 10;
  localparam int FB_ADDR_W   = 20;
  localparam int FB_DATA_W   = 12;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FILL  = 2'd2
  } fb_state_t;

  // RAM address layout shared with the pixel generator: {x, y}.
  function automatic logic [FB_ADDR_W-1:0] fb_pack_addr(
    input logic [FB_COORD_W-1:0] x,
    input logic [FB_COORD_W-1:0] y
  );
    return {x, y};
  endfunction

endpackage

// File: rtl/fb_scan_counter.sv
// Loadable raster counter: x is the inner loop from xmin to xmax, y the outer
// loop up to ymax. After reset it covers the whole visible area from (0,0).
module fb_scan_counter
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = FB_H_ACTIVE,
  parameter int V_ACTIVE = FB_V_ACTIVE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FB_COORD_W-1:0] load_x,
  input  logic [FB_COORD_W-1:0] load_y,
  input  logic [FB_COORD_W-1:0] load_xmax,
  input  logic [FB_COORD_W-1:0] load_ymax,
  input  logic                  advance,
  output logic [FB_COORD_W-1:0] x,
  output logic [FB_COORD_W-1:0] y,
  output logic                  last
);

  localparam logic [FB_COORD_W-1:0] XMAX_FULL = FB_COORD_W'(H_ACTIVE - 1);
  localparam logic [FB_COORD_W-1:0] YMAX_FULL = FB_COORD_W'(V_ACTIVE - 1);

  logic [FB_COORD_W-1:0] xmin;
  logic [FB_COORD_W-1:0] xmax;
  logic [FB_COORD_W-1:0] ymax;

  // Position and bounds; load wins over advance, x wraps back to its start column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      xmin <= '0;
      xmax <= XMAX_FULL;
      ymax <= YMAX_FULL;
    end else if (load) begin
      x    <= load_x;
      y    <= load_y;
      xmin <= load_x;
      xmax <= load_xmax;
      ymax <= load_ymax;
    end else if (advance) begin
      if (x == xmax) begin
        x <= xmin;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == xmax) && (y == ymax);

endmodule

// File: rtl/fb_rect_writer.sv
// Framebuffer write engine: clears the visible area after reset, then fills
// clipped rectangles one pixel per cycle in raster order. A one-cycle "drain"
// step after the last write gives the registered done/cmd_ready timing.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int                   H_ACTIVE    = FB_H_ACTIVE,
  parameter int                   V_ACTIVE    = FB_V_ACTIVE,
  parameter logic [FB_DATA_W-1:0] CLEAR_COLOR = 12'h000
) (
  input  logic                  clk_d,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [FB_COORD_W-1:0] cmd_x0,
  input  logic [FB_COORD_W-1:0] cmd_y0,
  input  logic [FB_COORD_W-1:0] cmd_x1,
  input  logic [FB_COORD_W-1:0] cmd_y1,
  input  logic [FB_DATA_W-1:0]  cmd_color,
  input  logic                  hold,
  output logic [FB_ADDR_W-1:0]  wr_addr,
  output logic [FB_DATA_W-1:0]  wr_data,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  init_done
);

  localparam logic [FB_COORD_W-1:0] XMAX = FB_COORD_W'(H_ACTIVE - 1);
  localparam logic [FB_COORD_W-1:0] YMAX = FB_COORD_W'(V_ACTIVE - 1);

  fb_state_t             state, state_nx;
  logic                  drain, drain_nx;
  logic [FB_DATA_W-1:0]  color;
  logic [FB_COORD_W-1:0] x1c, y1c;
  logic                  empty, accept;
  logic                  issue, fin;
  logic                  cnt_load, cnt_adv, cnt_last;
  logic [FB_COORD_W-1:0] cnt_x, cnt_y;

  logic                  wr_en_nx, done_nx, init_done_nx, cmd_ready_nx, busy_nx;
  logic [FB_ADDR_W-1:0]  wr_addr_nx;
  logic [FB_DATA_W-1:0]  wr_data_nx;

  // Clip the far corner to the visible area and detect empty rectangles.
  always_comb begin
    x1c    = (cmd_x1 > XMAX) ? XMAX : cmd_x1;
    y1c    = (cmd_y1 > YMAX) ? YMAX : cmd_y1;
    empty  = (cmd_x0 > x1c) || (cmd_y0 > y1c);
    accept = (state == ST_IDLE) && cmd_valid && cmd_ready;
  end

  fb_scan_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_scan (
    .clk       (clk_d),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .load_x    (cmd_x0),
    .load_y    (cmd_y0),
    .load_xmax (x1c),
    .load_ymax (y1c),
    .advance   (cnt_adv),
    .x         (cnt_x),
    .y         (cnt_y),
    .last      (cnt_last)
  );

  // State register; reset restarts the clear and drops any pending completion.
  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      drain <= 1'b0;
    end else begin
      state <= state_nx;
      drain <= drain_nx;
    end
  end

  // Fill colour is captured at accept only, so later cmd_* changes are ignored.
  always_ff @(posedge clk_d) begin
    if (accept) begin
      color <= cmd_color;
    end
  end

  // Next-state logic: issue one pixel per unheld cycle, drain one cycle at the end.
  always_comb begin
    state_nx = state;
    drain_nx = drain;
    issue    = 1'b0;
    fin      = 1'b0;
    cnt_load = 1'b0;
    cnt_adv  = 1'b0;
    case (state)
      ST_CLEAR, ST_FILL: begin
        if (drain) begin
          fin      = 1'b1;
          drain_nx = 1'b0;
          state_nx = ST_IDLE;
        end else if (!hold) begin
          issue = 1'b1;
          if (cnt_last) begin
            drain_nx = 1'b1;
          end else begin
            cnt_adv = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          state_nx = ST_FILL;
          drain_nx = empty;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        drain_nx = 1'b0;
      end
    endcase
  end

  // Output decode: values the output registers take at the next edge.
  always_comb begin
    wr_en_nx     = issue;
    wr_addr_nx   = issue ? fb_pack_addr(cnt_x, cnt_y) : wr_addr;
    wr_data_nx   = wr_data;
    if (issue) begin
      wr_data_nx = (state == ST_CLEAR) ? CLEAR_COLOR : color;
    end
    done_nx      = fin;
    init_done_nx = init_done || (fin && (state == ST_CLEAR));
    cmd_ready_nx = (state_nx == ST_IDLE);
    busy_nx      = (state_nx != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      init_done <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      done      <= done_nx;
      init_done <= init_done_nx;
      cmd_ready <= cmd_ready_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer on a reduced 40x30 visible area.
module tb_fb_rect_writer;

  localparam int          HA = 40;
  localparam int          VA = 30;
  localparam logic [11:0] CC = 12'h5A3;

  logic        clk_d = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [11:0] cmd_color = '0;
  logic        hold = 1'b0;
  logic [19:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_en, busy, done, init_done;

  int vectors = 0;
  int miscompares = 0;

  fb_rect_writer #(
    .H_ACTIVE    (HA),
    .V_ACTIVE    (VA),
    .CLEAR_COLOR (CC)
  ) dut (
    .clk_d     (clk_d),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .hold      (hold),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done),
    .init_done (init_done)
  );

  always #5 clk_d = ~clk_d;

  task automatic step();
    @(posedge clk_d);
    #1;
  endtask

  task automatic issue_cmd(input int x0, input int y0, input int x1, input int y1,
                           input logic [11:0] col);
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
    cmd_color = col;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    // scramble the command bus; the accepted command must already be latched
    cmd_x0 = 10'd1; cmd_y0 = 10'd1; cmd_x1 = 10'd2; cmd_y1 = 10'd2;
    cmd_color = 12'h111;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    vectors++; if (wr_addr !== 20'h0) begin miscompares++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
    vectors++; if (wr_data !== 12'h0) begin miscompares++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done got %b want 0", init_done); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy got %b want 1", busy); end
  endtask

  task automatic check_full_clear(input string tag);
    logic [19:0] ea;
    for (int i = 0; i < HA * VA; i++) begin
      step();
      ea = {10'(i % HA), 10'(i / HA)};
      vectors++;
      if ({wr_en, wr_addr, wr_data, done, cmd_ready, busy} !== {1'b1, ea, CC, 1'b0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL %s_pix%0d got en=%b addr=%h data=%h done=%b rdy=%b busy=%b want en=1 addr=%h data=%h done=0 rdy=0 busy=1",
                 tag, i, wr_en, wr_addr, wr_data, done, cmd_ready, busy, ea, CC);
      end
    end
    step();
    vectors++;
    if ({wr_en, done, init_done, cmd_ready, busy} !== 5'b01110) begin
      miscompares++;
      $display("FAIL %s_end got en=%b done=%b init=%b rdy=%b busy=%b want 0 1 1 1 0",
               tag, wr_en, done, init_done, cmd_ready, busy);
    end
    step();
    vectors++;
    if ({wr_en, done, init_done, cmd_ready} !== 4'b0011) begin
      miscompares++;
      $display("FAIL %s_after got en=%b done=%b init=%b rdy=%b want 0 0 1 1",
               tag, wr_en, done, init_done, cmd_ready);
    end
  endtask

  task automatic test_clear();
    rst_n = 1'b1;
    check_full_clear("clear");
  endtask

  task automatic test_fill_basic();
    logic [19:0] ea;
    int n = 0;
    issue_cmd(10, 20, 12, 21, 12'hF0A);
    vectors++;
    if ({cmd_ready, busy, wr_en} !== 3'b010) begin
      miscompares++;
      $display("FAIL basic_accept got rdy=%b busy=%b en=%b want 0 1 0", cmd_ready, busy, wr_en);
    end
    for (int y = 20; y <= 21; y++) begin
      for (int x = 10; x <= 12; x++) begin
        step();
        ea = {10'(x), 10'(y)};
        vectors++;
        if ({wr_en, wr_addr, wr_data, done, cmd_ready} !== {1'b1, ea, 12'hF0A, 1'b0, 1'b0}) begin
          miscompares++;
          $display("FAIL basic_pix%0d got en=%b addr=%h data=%h done=%b rdy=%b want en=1 addr=%h data=f0a",
                   n, wr_en, wr_addr, wr_data, done, cmd_ready, ea);
        end
        n++;
      end
    end
    step();
    vectors++;
    if ({wr_en, done, cmd_ready, busy} !== 4'b0110) begin
      miscompares++;
      $display("FAIL basic_done got en=%b done=%b rdy=%b busy=%b want 0 1 1 0", wr_en, done, cmd_ready, busy);
    end
    step();
    vectors++;
    if ({wr_en, done, cmd_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL basic_after got en=%b done=%b rdy=%b want 0 0 1", wr_en, done, cmd_ready);
    end
  endtask

  task automatic test_fill_clip();
    logic [19:0] ea;
    issue_cmd(30, 20, 1000, 1000, 12'h0F0);
    for (int y = 20; y < VA; y++) begin
      for (int x = 30; x < HA; x++) begin
        step();
        ea = {10'(x), 10'(y)};
        vectors++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, ea, 12'h0F0}) begin
          miscompares++;
          $display("FAIL clip_pix x=%0d y=%0d got en=%b addr=%h data=%h want en=1 addr=%h data=0f0",
                   x, y, wr_en, wr_addr, wr_data, ea);
        end
      end
    end
    step();
    vectors++;
    if ({wr_en, done, cmd_ready} !== 3'b011) begin
      miscompares++;
      $display("FAIL clip_done got en=%b done=%b rdy=%b want 0 1 1", wr_en, done, cmd_ready);
    end
    step();
  endtask

  task automatic test_fill_empty();
    int ex0[2] = '{5, 0};
    int ey0[2] = '{5, 35};
    int ex1[2] = '{4, 3};
    int ey1[2] = '{9, 40};
    for (int k = 0; k < 2; k++) begin
      issue_cmd(ex0[k], ey0[k], ex1[k], ey1[k], 12'hEEE);
      vectors++;
      if ({wr_en, done, cmd_ready, busy} !== 4'b0001) begin
        miscompares++;
        $display("FAIL empty%0d_accept got en=%b done=%b rdy=%b busy=%b want 0 0 0 1",
                 k, wr_en, done, cmd_ready, busy);
      end
      step();
      vectors++;
      if ({wr_en, done, cmd_ready, busy} !== 4'b0110) begin
        miscompares++;
        $display("FAIL empty%0d_done got en=%b done=%b rdy=%b busy=%b want 0 1 1 0",
                 k, wr_en, done, cmd_ready, busy);
      end
      step();
      vectors++;
      if ({wr_en, done, cmd_ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL empty%0d_after got en=%b done=%b rdy=%b want 0 0 1", k, wr_en, done, cmd_ready);
      end
    end
  endtask

  task automatic test_hold();
    logic en_exp[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   x_exp[7]  = '{2, 3, 0, 0, 0, 4, 5};
    logic [19:0] ea;
    issue_cmd(2, 3, 5, 3, 12'hABC);
    for (int c = 0; c < 7; c++) begin
      step();
      ea = {10'(x_exp[c]), 10'd3};
      vectors++;
      if (en_exp[c]) begin
        if ({wr_en, wr_addr, wr_data, done} !== {1'b1, ea, 12'hABC, 1'b0}) begin
          miscompares++;
          $display("FAIL hold_cyc%0d got en=%b addr=%h data=%h done=%b want en=1 addr=%h data=abc done=0",
                   c, wr_en, wr_addr, wr_data, done, ea);
        end
      end else if ({wr_en, done} !== 2'b00) begin
        miscompares++;
        $display("FAIL hold_cyc%0d got en=%b done=%b want en=0 done=0", c, wr_en, done);
      end
      hold = (c >= 1 && c <= 3);
    end
    step();
    vectors++;
    if ({wr_en, done, cmd_ready} !== 3'b011) begin
      miscompares++;
      $display("FAIL hold_done got en=%b done=%b rdy=%b want 0 1 1", wr_en, done, cmd_ready);
    end
    step();
  endtask

  task automatic test_reset_mid_fill();
    issue_cmd(0, 0, 9, 9, 12'hFFF);
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if ({wr_en, wr_data} !== {1'b1, 12'hFFF}) begin
        miscompares++;
        $display("FAIL rstfill_pre%0d got en=%b data=%h want en=1 data=fff", c, wr_en, wr_data);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({wr_en, busy, cmd_ready, done, init_done} !== 5'b01000) begin
      miscompares++;
      $display("FAIL rstfill_async got en=%b busy=%b rdy=%b done=%b init=%b want 0 1 0 0 0",
               wr_en, busy, cmd_ready, done, init_done);
    end
    step();
    rst_n = 1'b1;
    check_full_clear("reclear");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_fill_basic();
    test_fill_clip();
    test_fill_empty();
    test_hold();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
